mlp_layer_seq: RTL and testbench
================================

// Module: mlp_layer_seq
// PURPOSE
//   Sequential, parametrised binary MLP layer for the BNN datapath.
//   Per neuron: XNOR of the input vector with its weight row, popcount, compare
//   against a per-neuron threshold. Processes CHUNK bits per cycle, one neuron at
//   a time, so one small popcount/accumulator is shared by all neurons.
//   Takes the flattened conv feature map and delivers class bits to the readout.
// PARAMETERS
//   INPUT_SIZE       288  input vector width in bits; must be a multiple of CHUNK
//   OUTPUT_SIZE      8    neuron count; must be >= 2
//   CHUNK            8    input bits consumed per cycle
//   THRESHOLD_WIDTH  $clog2(INPUT_SIZE+1)  derived; popcount/threshold width
// PORTS
//   clk        in   1                          clock, rising edge
//   rst        in   1                          asynchronous reset, active-high
//   in         in   INPUT_SIZE                 input activations, sampled on accept
//   in_valid   in   1                          input vector valid
//   in_ready   out  1                          block can accept a vector
//   weight     in   INPUT_SIZE*OUTPUT_SIZE     neuron i row = weight[i*INPUT_SIZE +: INPUT_SIZE]
//   threshold  in   OUTPUT_SIZE*THRESHOLD_WIDTH  neuron i = threshold[i*THRESHOLD_WIDTH +: THRESHOLD_WIDTH]
//   out        out  OUTPUT_SIZE                neuron output bits
//   out_valid  out  1                          out is valid
//   out_ready  in   1                          consumer accepts out
// BEHAVIOUR
//   - Reset: state=IDLE, in_ready=1, out_valid=0, out=0, counters/accumulator=0.
//     Reset asserted mid-RUN or mid-DONE aborts; the partial result is discarded.
//   - IDLE: in_ready=1. in_valid&in_ready -> latch in, chunk=0, neuron=0, acc=0,
//     go RUN. in_ready=0 in RUN and DONE; in_valid is ignored there.
//   - RUN, each cycle: pc = popcount(~(in_l[c] ^ w[n][c])) over CHUNK bits,
//     c = chunk index (LSB chunk first); acc += pc.
//     On the last chunk: out[n] <= (acc+pc >= threshold[n]) (unsigned); acc <= 0;
//     chunk <= 0; n++. After the last neuron -> DONE.
//   - acc is THRESHOLD_WIDTH bits and cannot overflow (max = INPUT_SIZE).
//   - weight/threshold are sampled live during RUN and must be stable from accept
//     until out_valid.
//   - Latency: RUN lasts OUTPUT_SIZE*INPUT_SIZE/CHUNK cycles (288 at defaults).
//     out_valid rises on the cycle after the last RUN cycle.
//   - DONE: out_valid=1 and out held stable until out_valid&out_ready; then IDLE
//     with out_valid=0 and in_ready=1 on the next cycle. out keeps its last value.
//   - threshold=0: the neuron always fires. threshold>INPUT_SIZE: it never fires.
// CONFIGURATION
//   MLP_ARGMAX_EN defined:
//     - Adds out port class_idx [$clog2(OUTPUT_SIZE)] and out port
//       class_score [THRESHOLD_WIDTH].
//     - Tracks the maximum full-neuron popcount during RUN. Strictly-greater
//       compare, so on a tie the lowest index wins.
//     - Both ports are valid and held with out_valid; reset value is 0.
//   MLP_ARGMAX_EN undefined: the ports and tracking logic are absent;
//     out/handshake behaviour is identical.
// TESTING  (bench params INPUT_SIZE=16, OUTPUT_SIZE=4, CHUNK=4 -> 16 RUN cycles)
//   1. in=16'hFFFF, all weights 16'hFFFF, thresholds 16 -> out=4'b1111;
//      out_valid exactly 17 cycles after the accept edge.
//   2. in=16'hFFFF, w0=16'h0000 (pc=0); thr0=0 -> out[0]=1; thr0=1 -> out[0]=0;
//      w1=16'h00FF, thr1=8 -> out[1]=1; thr1=9 -> out[1]=0.
//   3. Hold out_ready=0 for 10 cycles after out_valid -> out and out_valid held,
//      in_ready=0, a pulsed in_valid is ignored; out_ready=1 -> in_ready=1 next cycle.
//   4. Assert rst at RUN cycle 5 -> out_valid=0, out=0, in_ready=1 immediately;
//      a new transaction afterwards yields results matching a golden model.
//   5. [MLP_ARGMAX_EN] neuron popcounts 5,12,12,3 -> class_idx=1, class_score=12.
//   6. in_valid and out_ready held high, 3 random vectors back-to-back -> one
//      result per 18 cycles, each matching the golden model; no vector dropped.

Source files
------------

// File: rtl/mlp_layer_seq.sv
// rtl/mlp_layer_seq.sv - sequential XNOR/popcount/threshold binary MLP layer, CHUNK bits per cycle
// Optional MLP_ARGMAX_EN adds class_idx/class_score tracking of the strongest neuron.
module mlp_layer_seq #(
    parameter int INPUT_SIZE      = 288,
    parameter int OUTPUT_SIZE     = 8,
    parameter int CHUNK           = 8,
    parameter int THRESHOLD_WIDTH = $clog2(INPUT_SIZE + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [INPUT_SIZE-1:0]                  in,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [INPUT_SIZE*OUTPUT_SIZE-1:0]      weight,
    input  logic [OUTPUT_SIZE*THRESHOLD_WIDTH-1:0] threshold,
    output logic [OUTPUT_SIZE-1:0]                 out,
    output logic                                   out_valid,
    input  logic                                   out_ready
`ifdef MLP_ARGMAX_EN
    ,
    output logic [$clog2(OUTPUT_SIZE)-1:0]         class_idx,
    output logic [THRESHOLD_WIDTH-1:0]             class_score
`endif
);
    localparam int NCHUNK = INPUT_SIZE / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int NW     = $clog2(OUTPUT_SIZE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                       state_q, state_d;
    logic [INPUT_SIZE-1:0]        in_l_q;
    logic [CW-1:0]                chunk_q;
    logic [NW-1:0]                neuron_q;
    logic [THRESHOLD_WIDTH-1:0]   acc_q;
    logic [OUTPUT_SIZE-1:0]       out_q;

    logic [INPUT_SIZE-1:0]        w_row;
    logic [THRESHOLD_WIDTH-1:0]   thr_sel;
    logic [CHUNK-1:0]             in_c, w_c, xn;
    logic [THRESHOLD_WIDTH-1:0]   pc, sum;
    logic                         last_chunk, last_neuron;

    // Constant-index mux trees keep every part-select static.
    always_comb begin
        w_row   = '0;
        thr_sel = '0;
        for (int i = 0; i < OUTPUT_SIZE; i++) begin
            if (neuron_q == NW'(i)) begin
                w_row   = weight[i*INPUT_SIZE +: INPUT_SIZE];
                thr_sel = threshold[i*THRESHOLD_WIDTH +: THRESHOLD_WIDTH];
            end
        end
        in_c = '0;
        w_c  = '0;
        for (int j = 0; j < NCHUNK; j++) begin
            if (chunk_q == CW'(j)) begin
                in_c = in_l_q[j*CHUNK +: CHUNK];
                w_c  = w_row[j*CHUNK +: CHUNK];
            end
        end
        xn = ~(in_c ^ w_c);
        pc = '0;
        for (int b = 0; b < CHUNK; b++) begin
            pc = pc + THRESHOLD_WIDTH'(xn[b]);
        end
        sum         = acc_q + pc;
        last_chunk  = (chunk_q == CW'(NCHUNK - 1));
        last_neuron = (neuron_q == NW'(OUTPUT_SIZE - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last_chunk && last_neuron) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

`ifdef MLP_ARGMAX_EN
    logic [THRESHOLD_WIDTH-1:0] max_q;
    logic [NW-1:0]              idx_q;

    // Strictly-greater update: on a tie the earlier (lower) neuron keeps the win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q <= '0;
            idx_q <= '0;
        end else if (state_q == RUN && last_chunk) begin
            if (neuron_q == '0 || sum > max_q) begin
                max_q <= sum;
                idx_q <= neuron_q;
            end
        end
    end

    assign class_idx   = idx_q;
    assign class_score = max_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_l_q   <= '0;
            chunk_q  <= '0;
            neuron_q <= '0;
            acc_q    <= '0;
            out_q    <= '0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                in_l_q   <= in;
                chunk_q  <= '0;
                neuron_q <= '0;
                acc_q    <= '0;
            end else if (state_q == RUN) begin
                if (last_chunk) begin
                    out_q[neuron_q] <= (sum >= thr_sel);
                    acc_q           <= '0;
                    chunk_q         <= '0;
                    neuron_q        <= last_neuron ? '0 : neuron_q + NW'(1);
                end else begin
                    acc_q   <= sum;
                    chunk_q <= chunk_q + CW'(1);
                end
            end
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_mlp_layer_seq.sv
// tb/tb_mlp_layer_seq.sv - scoreboard bench for mlp_layer_seq (16-bit input, 4 neurons, 4-bit chunks)
// Build with +define+MLP_ARGMAX_EN to also cover the class_idx/class_score ports.
module tb_mlp_layer_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_v;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] weight;
    logic [19:0] threshold;
    logic [3:0]  out_v;
    logic        out_valid;
    logic        out_ready;
`ifdef MLP_ARGMAX_EN
    logic [1:0]  class_idx;
    logic [4:0]  class_score;
`endif

    mlp_layer_seq #(.INPUT_SIZE(16), .OUTPUT_SIZE(4), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_v),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .weight    (weight),
        .threshold (threshold),
        .out       (out_v),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MLP_ARGMAX_EN
        ,
        .class_idx   (class_idx),
        .class_score (class_score)
`endif
    );

    always #5 clk = ~clk;

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         n_pushed  = 0;
    int         n_results = 0;
    int         cyc_cnt   = 0;
    logic [3:0] exp_q[$];
    logic [3:0] sb_exp;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model(input logic [15:0] x, input logic [63:0] w,
                                         input logic [19:0] t);
        logic [3:0] r;
        int         c;
        for (int n = 0; n < 4; n++) begin
            c    = $countones(~(x ^ w[n*16 +: 16]));
            r[n] = (c >= int'(t[n*5 +: 5]));
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_out", 32'(out_v), 32'(sb_exp));
                n_results++;
            end
        end
    end

    task automatic send(input logic [15:0] v, input bit push);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) check("send_in_ready_timeout", 32'(in_ready), 32'd1);
        in_v     = v;
        in_valid = 1'b1;
        if (push) begin
            exp_q.push_back(model(v, weight, threshold));
            n_pushed++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic randomize_params();
        weight = {$urandom, $urandom};
        for (int n = 0; n < 4; n++) threshold[n*5 +: 5] = 5'($urandom_range(0, 17));
    endtask

    initial begin
        int         cyc;
        int         t;
        int         acc_t[3];
        logic [3:0] held;

        rst = 1'b1; in_v = '0; in_valid = 1'b0; out_ready = 1'b1;
        weight = '0; threshold = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out_v), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: all-ones, threshold at the maximum popcount, latency measured in cycles.
        weight = {4{16'hFFFF}};
        threshold = {4{5'd16}};
        send(16'hFFFF, 1'b1);
        cyc = 1;
        t   = 0;
        forever begin
            @(negedge clk);
            if (out_valid || t > 40) break;
            @(posedge clk); #1;
            cyc++;
            t++;
        end
        check("t1_out", 32'(out_v), 32'hF);
        check("t1_latency", 32'(cyc), 32'd17);
        @(posedge clk); #1;

        // 2: threshold boundaries (0 always fires, exact popcount fires, popcount+1 does not).
        weight    = {16'hFFFF, 16'hFFFF, 16'h00FF, 16'h0000};
        threshold = {5'd16, 5'd16, 5'd8, 5'd0};
        send(16'hFFFF, 1'b1);
        wait_out();
        check("t2_fire", 32'(out_v), 32'b1111);
        @(posedge clk); #1;
        threshold = {5'd16, 5'd16, 5'd9, 5'd1};
        send(16'hFFFF, 1'b1);
        wait_out();
        check("t2_nofire", 32'(out_v), 32'b1100);
        @(posedge clk); #1;

        // 3: backpressure on the result; a stray in_valid while DONE must be ignored.
        randomize_params();
        out_ready = 1'b0;
        held = model(16'hA5C3, weight, threshold);
        send(16'hA5C3, 1'b1);
        wait_out();
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_out", 32'(out_v), 32'(held));
            check("t3_hold_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            if (k == 4) begin in_valid = 1'b1; in_v = 16'($urandom); end
            if (k == 5) in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_release_in_ready", 32'(in_ready), 32'd1);
        check("t3_release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // 4: asynchronous reset in the middle of RUN, then a clean transaction.
        randomize_params();
        send(16'($urandom), 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t4_abort_out_valid", 32'(out_valid), 32'd0);
        check("t4_abort_out", 32'(out_v), 32'd0);
        check("t4_abort_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        randomize_params();
        send(16'($urandom), 1'b1);
        wait_out();
        @(posedge clk); #1;

`ifdef MLP_ARGMAX_EN
        // 5: popcounts 5,12,12,3 -> tie between neurons 1 and 2 goes to the lower index.
        weight    = {16'h0007, 16'hFFF0, 16'h0FFF, 16'h001F};
        threshold = {4{5'd8}};
        send(16'hFFFF, 1'b1);
        wait_out();
        check("t5_class_idx", 32'(class_idx), 32'd1);
        check("t5_class_score", 32'(class_score), 32'd12);
        @(posedge clk); #1;
`endif

        // 6: streaming with in_valid and out_ready held high.
        randomize_params();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_v     = 16'($urandom);
            in_valid = 1'b1;
            exp_q.push_back(model(in_v, weight, threshold));
            n_pushed++;
            t = 0;
            forever begin
                @(negedge clk);
                if (in_ready || t > 100) break;
                t++;
            end
            if (!in_ready) check("t6_accept_timeout", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            acc_t[k] = cyc_cnt;
        end
        in_valid = 1'b0;
        check("t6_period_01", 32'(acc_t[1] - acc_t[0]), 32'd18);
        check("t6_period_12", 32'(acc_t[2] - acc_t[1]), 32'd18);

        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        check("sb_result_count", 32'(n_results), 32'(n_pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
